// File: rtl/br_resolve.sv
// Execute-stage branch resolution: computes actual direction/target, raises a held
// redirect on mispredict, and pulses link write-back and predictor update. Optional stats: BR_STAT_EN.
module br_resolve (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_rj,
    input  logic [31:0] in_rd,
    input  logic [31:0] in_offs,
    input  logic        in_pred_taken,
    input  logic [31:0] in_pred_target,
    input  logic        flush,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_pc,
    output logic        link_valid,
    output logic [31:0] link_data,
    output logic        upd_valid,
    output logic [31:0] upd_pc,
    output logic        upd_taken,
    output logic [31:0] upd_target,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [3:0] OP_JIRL = 4'd1;
    localparam logic [3:0] OP_B    = 4'd2;
    localparam logic [3:0] OP_BL   = 4'd3;
    localparam logic [3:0] OP_BEQ  = 4'd4;
    localparam logic [3:0] OP_BNE  = 4'd5;
    localparam logic [3:0] OP_BLT  = 4'd6;
    localparam logic [3:0] OP_BGE  = 4'd7;
    localparam logic [3:0] OP_BLTU = 4'd8;
    localparam logic [3:0] OP_BGEU = 4'd9;

    function automatic logic resolve_taken(input logic [3:0] op, input logic [31:0] rj,
                                           input logic [31:0] rd);
        logic signed [31:0] rj_s;
        logic signed [31:0] rd_s;
        logic               t;
        rj_s = rj;
        rd_s = rd;
        case (op)
            OP_JIRL, OP_B, OP_BL: t = 1'b1;
            OP_BEQ:  t = (rj == rd);
            OP_BNE:  t = (rj != rd);
            OP_BLT:  t = (rj_s <  rd_s);
            OP_BGE:  t = (rj_s >= rd_s);
            OP_BLTU: t = (rj <  rd);
            OP_BGEU: t = (rj >= rd);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    state_t state_q, state_d;

    // Stage p0: combinational resolution of the presented branch
    logic        accept_p0, taken_p0, mispred_p0, link_p0;
    logic [31:0] target_p0, seq_pc_p0, next_pc_p0;

    assign in_ready   = (state_q == IDLE) & ~flush;
    assign accept_p0  = in_valid & in_ready;
    assign taken_p0   = resolve_taken(in_op, in_rj, in_rd);
    assign target_p0  = ((in_op == OP_JIRL) ? in_rj : in_pc) + in_offs;
    assign seq_pc_p0  = in_pc + 32'd4;
    assign next_pc_p0 = taken_p0 ? target_p0 : seq_pc_p0;
    assign link_p0    = (in_op == OP_JIRL) | (in_op == OP_BL);
    assign mispred_p0 = (in_pred_taken != taken_p0) |
                        (taken_p0 & (in_pred_target != target_p0));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_p0 & mispred_p0) state_d = HOLD;
            HOLD:    if (flush | redirect_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Stage p1: registered resolution results
    logic        vld_p1, link_vld_p1, upd_taken_p1;
    logic [31:0] redirect_pc_p1, link_data_p1, upd_pc_p1, upd_target_p1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p1         <= 1'b0;
            link_vld_p1    <= 1'b0;
            upd_taken_p1   <= 1'b0;
            redirect_pc_p1 <= '0;
            link_data_p1   <= '0;
            upd_pc_p1      <= '0;
            upd_target_p1  <= '0;
        end else begin
            vld_p1      <= accept_p0;
            link_vld_p1 <= accept_p0 & link_p0;
            if (accept_p0) begin
                upd_pc_p1     <= in_pc;
                upd_taken_p1  <= taken_p0;
                upd_target_p1 <= target_p0;
                if (mispred_p0) redirect_pc_p1 <= next_pc_p0;
                if (link_p0)    link_data_p1   <= seq_pc_p0;
            end
        end
    end

    assign redirect_valid = (state_q == HOLD);
    assign redirect_pc    = redirect_pc_p1;
    assign link_valid     = link_vld_p1;
    assign link_data      = link_data_p1;
    assign upd_valid      = vld_p1;
    assign upd_pc         = upd_pc_p1;
    assign upd_taken      = upd_taken_p1;
    assign upd_target     = upd_target_p1;

`ifdef BR_STAT_EN
    logic [31:0] br_cnt_p1, mp_cnt_p1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            br_cnt_p1 <= '0;
            mp_cnt_p1 <= '0;
        end else if (accept_p0) begin
            br_cnt_p1 <= br_cnt_p1 + 32'd1;
            if (mispred_p0) mp_cnt_p1 <= mp_cnt_p1 + 32'd1;
        end
    end

    assign stat_branches = br_cnt_p1;
    assign stat_mispred  = mp_cnt_p1;
`else
    assign stat_branches = '0;
    assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_br_resolve.sv
// Scoreboard bench for br_resolve: expectations queued at drive time, checked on upd_valid.
module tb_br_resolve;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [3:0]  in_op;
    logic [31:0] in_rj;
    logic [31:0] in_rd;
    logic [31:0] in_offs;
    logic        in_pred_taken;
    logic [31:0] in_pred_target;
    logic        flush;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [31:0] redirect_pc;
    logic        link_valid;
    logic [31:0] link_data;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;

    br_resolve dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_op(in_op),
        .in_rj(in_rj), .in_rd(in_rd), .in_offs(in_offs),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
        .flush(flush),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc),
        .link_valid(link_valid), .link_data(link_data),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
        logic        mp;
        logic [31:0] npc;
        logic        lk;
        logic [31:0] ld;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_br   = 0;
    int   exp_mp   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] pc,
                                   input logic [31:0] rj, input logic [31:0] rd,
                                   input logic [31:0] offs, input logic pt,
                                   input logic [31:0] ptgt);
        exp_t e;
        e.pc  = pc;
        e.tgt = pc + offs;
        case (op)
            4'd1: begin e.taken = 1'b1; e.tgt = rj + offs; end
            4'd2, 4'd3: e.taken = 1'b1;
            4'd4: e.taken = (rj == rd);
            4'd5: e.taken = (rj != rd);
            4'd6: e.taken = ($signed(rj) <  $signed(rd));
            4'd7: e.taken = ($signed(rj) >= $signed(rd));
            4'd8: e.taken = (rj <  rd);
            4'd9: e.taken = (rj >= rd);
            default: e.taken = 1'b0;
        endcase
        e.npc = e.taken ? e.tgt : pc + 32'd4;
        e.mp  = (pt != e.taken) || (e.taken && (ptgt != e.tgt));
        e.lk  = (op == 4'd1) || (op == 4'd3);
        e.ld  = pc + 32'd4;
        return e;
    endfunction

    // Advance to the next falling edge and retire any update pulse against the scoreboard.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (upd_valid) begin
            if (sb.size() == 0) begin
                check("upd_extra", 32'(upd_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("upd_pc", upd_pc, e.pc);
                check("upd_taken", 32'(upd_taken), 32'(e.taken));
                check("upd_target", upd_target, e.tgt);
                check("link_valid", 32'(link_valid), 32'(e.lk));
                check("redirect_valid", 32'(redirect_valid), 32'(e.mp));
                if (e.lk) check("link_data", link_data, e.ld);
                if (e.mp) check("redirect_pc", redirect_pc, e.npc);
            end
        end
        check("sb_pending", 32'(sb.size()), 32'd0);
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] rj,
                        input logic [31:0] rd, input logic [31:0] offs, input logic pt,
                        input logic [31:0] ptgt);
        exp_t e;
        check("in_ready_pre", 32'(in_ready), 32'd1);
        e = model(op, pc, rj, rd, offs, pt, ptgt);
        sb.push_back(e);
        exp_br++;
        if (e.mp) exp_mp++;
        in_valid = 1'b1; in_op = op; in_pc = pc; in_rj = rj; in_rd = rd;
        in_offs = offs; in_pred_taken = pt; in_pred_target = ptgt;
        step();
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        redirect_ready = 1'b1;
        step();
        check("hs_redirect_fall", 32'(redirect_valid), 32'd0);
        check("hs_in_ready", 32'(in_ready), 32'd1);
        redirect_ready = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_pc = '0; in_op = '0; in_rj = '0; in_rd = '0;
        in_offs = '0; in_pred_taken = 1'b0; in_pred_target = '0; flush = 1'b0;
        redirect_ready = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        step();
        check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        check("rst_link_valid", 32'(link_valid), 32'd0);
        check("rst_upd_valid", 32'(upd_valid), 32'd0);
        check("rst_upd_taken", 32'(upd_taken), 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_link_data", link_data, 32'd0);
        check("rst_upd_pc", upd_pc, 32'd0);
        check("rst_upd_target", upd_target, 32'd0);
        check("rst_stat_br", stat_branches, 32'd0);
        check("rst_stat_mp", stat_mispred, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // BEQ mispredict, held redirect with a competing branch presented
        send(4'd4, 32'h1c000100, 32'd5, 32'd5, 32'h40, 1'b0, 32'h0);
        check("beq_redirect_valid", 32'(redirect_valid), 32'd1);
        check("beq_redirect_pc", redirect_pc, 32'h1c000140);
        check("beq_upd_target", upd_target, 32'h1c000140);
        check("beq_link_valid", 32'(link_valid), 32'd0);
        in_valid = 1'b1; in_op = 4'd2; in_pc = 32'h1c000900; in_offs = 32'h10;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_redirect_valid", 32'(redirect_valid), 32'd1);
            check("hold_redirect_pc", redirect_pc, 32'h1c000140);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        handshake();

        // Signed vs unsigned compare on rj=-1, rd=1
        send(4'd6, 32'h1c000300, 32'hFFFFFFFF, 32'd1, 32'h10, 1'b1, 32'h1c000310);
        check("blt_taken", 32'(upd_taken), 32'd1);
        check("blt_no_redirect", 32'(redirect_valid), 32'd0);
        send(4'd8, 32'h1c000304, 32'hFFFFFFFF, 32'd1, 32'h10, 1'b1, 32'h1c000314);
        check("bltu_taken", 32'(upd_taken), 32'd0);
        check("bltu_redirect_pc", redirect_pc, 32'h1c000308);
        handshake();

        // JIRL target mismatch with link
        send(4'd1, 32'h1c000200, 32'h1c001000, 32'd0, 32'd8, 1'b1, 32'h1c001004);
        check("jirl_redirect_pc", redirect_pc, 32'h1c001008);
        check("jirl_link_valid", 32'(link_valid), 32'd1);
        check("jirl_link_data", link_data, 32'h1c000204);
        handshake();

        // Back-to-back correct predictions
        send(4'd2, 32'h1c000400, 32'd0, 32'd0, 32'h20, 1'b1, 32'h1c000420);
        check("b2b_ready_1", 32'(in_ready), 32'd1);
        check("b2b_redirect_1", 32'(redirect_valid), 32'd0);
        send(4'd5, 32'h1c000420, 32'd1, 32'd2, 32'hFFFFFFF8, 1'b1, 32'h1c000418);
        check("b2b_upd_valid_2", 32'(upd_valid), 32'd1);
        check("b2b_ready_2", 32'(in_ready), 32'd1);
        check("b2b_redirect_2", 32'(redirect_valid), 32'd0);
        step();
        check("b2b_pulse_end", 32'(upd_valid), 32'd0);

        // Wrapping target, then flush drops the held redirect and blocks acceptance
        send(4'd2, 32'hFFFFFFFC, 32'd0, 32'd0, 32'd8, 1'b0, 32'h0);
        check("wrap_target", upd_target, 32'h00000004);
        check("wrap_redirect_pc", redirect_pc, 32'h00000004);
        flush = 1'b1; in_valid = 1'b1; in_op = 4'd3; in_pc = 32'h1c000a00;
        step();
        check("flush_redirect_fall", 32'(redirect_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        step();
        check("post_flush_ready", 32'(in_ready), 32'd1);
        check("post_flush_link", 32'(link_valid), 32'd0);

        // Illegal op predicted taken
        send(4'd12, 32'h1c000500, 32'd0, 32'd0, 32'h40, 1'b1, 32'h1c000540);
        check("illegal_redirect_pc", redirect_pc, 32'h1c000504);
        check("illegal_link", 32'(link_valid), 32'd0);
        handshake();

`ifdef BR_STAT_EN
        check("stat_branches", stat_branches, 32'(exp_br));
        check("stat_mispred", stat_mispred, 32'(exp_mp));
`else
        check("stat_branches_off", stat_branches, 32'd0);
        check("stat_mispred_off", stat_mispred, 32'd0);
`endif

        // Asynchronous reset while holding a redirect
        send(4'd5, 32'h1c000600, 32'd7, 32'd7, 32'h10, 1'b1, 32'h1c000610);
        check("rsthold_redirect_valid", 32'(redirect_valid), 32'd1);
        #2 resetn = 1'b0;
        #1 check("rsthold_drop", 32'(redirect_valid), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        step();
        check("rsthold_in_ready", 32'(in_ready), 32'd1);
        check("rsthold_stat_br", stat_branches, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/br_resolve.md
# br_resolve

Execute-stage branch resolution unit: the checking end of the fetch-side branch prediction path. It takes one branch per handshake with its operands and the front-end's prediction. It computes the actual direction and target, and produces three registered outputs: a redirect/flush request on misprediction, a link write-back for `bl`/`jirl`, and a predictor update pulse. It sits between the issue/execute pipeline register and the fetch PC-select logic.

## Interface
- No parameters.
- `clk` in 1: sole clock.
- `resetn` in 1: asynchronous, active-low reset.
- `in_valid` in 1: branch presented.
- `in_ready` out 1: branch can be accepted.
- `in_pc` in 32: PC of the branch.
- `in_op` in 4: branch kind. Encoding: 1 JIRL, 2 B, 3 BL, 4 BEQ, 5 BNE, 6 BLT, 7 BGE, 8 BLTU, 9 BGEU. 0 and 10–15 are illegal.
- `in_rj` in 32: rj value (jirl base / compare lhs).
- `in_rd` in 32: rd value (compare rhs).
- `in_offs` in 32: sign-extended byte offset, already shifted left by 2.
- `in_pred_taken` in 1: front-end predicted taken.
- `in_pred_target` in 32: front-end predicted target.
- `flush` in 1: higher-priority pipeline flush (exception/ertn).
- `redirect_valid` out 1: misprediction redirect pending.
- `redirect_ready` in 1: fetch accepts redirect.
- `redirect_pc` out 32: correct next PC.
- `link_valid` out 1: one-cycle pulse to write the link register.
- `link_data` out 32: pc+4.
- `upd_valid` out 1: one-cycle predictor update pulse.
- `upd_pc` out 32: resolved branch PC.
- `upd_taken` out 1: actual direction.
- `upd_target` out 32: actual taken target.
- `stat_branches` out 32: resolved-branch counter (see Configuration).
- `stat_mispred` out 32: mispredict counter (see Configuration).

## Operation
- Accept when `in_valid & in_ready`.
- Taken rule:
  - JIRL, B, BL: always taken.
  - BEQ: `rj==rd`. BNE: `rj!=rd`.
  - BLT/BGE: signed `rj<rd` / `rj>=rd`.
  - BLTU/BGEU: unsigned.
  - Illegal op: not taken, no link.
- Target rule:
  - JIRL: `rj+offs`.
  - All other ops: `pc+offs`.
  - 32-bit add, carry discarded (wraps).
- Actual next PC: `taken ? target : pc+4`, with pc+4 wrapping at 2^32.
- Mispredict: `pred_taken != taken`, or `taken & (pred_target != target)`. When not taken, `pred_target` is ignored.
- Link: BL and JIRL only, `link_data = pc+4`.
- State machine, 2 states:
  - IDLE → HOLD: an accepted branch mispredicts.
  - HOLD → IDLE: `redirect_valid & redirect_ready`, or `flush`.
- `in_ready` = (state==IDLE) & ~flush.
- `redirect_pc` is stable while HOLD.
- `flush` in any state:
  - drops the pending redirect;
  - suppresses any acceptance that cycle;
  - does not cancel link/upd pulses registered the previous cycle.
- Reset mid-HOLD: returns to IDLE and drops the redirect.

## Timing
- Accept in cycle N → in cycle N+1:
  - `link_valid`/`upd_valid` pulse high for exactly one cycle;
  - `redirect_valid` rises if mispredicted.
- `redirect_valid` stays high until the handshake completes; it falls in the cycle after the handshake.
- No new acceptance from cycle N+1 until the cycle after the redirect handshake; `in_ready` is 0 throughout.
- Correctly predicted branches may be accepted back-to-back, one per cycle.
- Reset values:
  - state IDLE;
  - `redirect_valid`, `link_valid`, `upd_valid`, `upd_taken` all 0;
  - `redirect_pc`, `link_data`, `upd_pc`, `upd_target` 0;
  - stat counters 0;
  - `in_ready` 1 after reset deasserts.

## Configuration
- `BR_STAT_EN` defined:
  - `stat_branches` increments on every acceptance;
  - `stat_mispred` increments on every acceptance that mispredicts;
  - both counters increment in cycle N+1, wrap at 2^32 and reset to 0.
- `BR_STAT_EN` undefined: both ports are tied to constant 0 and no counter flops exist.

## Test plan
- BEQ mispredict, then redirect: pc=0x1c000100, rj=rd=5, offs=0x40, pred_taken=0.
  - N+1: `redirect_valid=1`, `redirect_pc=0x1c000140`, `upd_taken=1`, `upd_target=0x1c000140`, `link_valid=0`.
  - Hold `redirect_ready=0` for 3 cycles: outputs stable and `in_ready=0`.
  - Then assert ready: IDLE one cycle later.
- BLT signed vs BLTU unsigned: rj=0xFFFFFFFF, rd=1.
  - BLT: taken.
  - BLTU: not taken, `redirect_pc=pc+4` when predicted taken.
- JIRL target mismatch with link: pc=0x1c000200, rj=0x1c001000, offs=8, pred_taken=1, pred_target=0x1c001004.
  - `redirect_pc=0x1c001008`.
  - `link_valid=1`, `link_data=0x1c000204`.
- Back-to-back correct predictions: B then BNE(taken) accepted in consecutive cycles, both predicted exactly.
  - Two consecutive `upd_valid` pulses.
  - No `redirect_valid`; `in_ready` stays 1.
- Flush and wrap during HOLD:
  - `flush=1` during HOLD: `redirect_valid` falls next cycle, no handshake needed.
  - B at pc=0xFFFFFFFC, offs=8: target=0x00000004 (wrap).
- `BR_STAT_EN`: after the five scenarios above, `stat_branches` and `stat_mispred` match the counted events. With the macro undefined, both read 0.
